// File: rtl/opcode_sched_pkg.sv
// Shared types for the opcode source scheduler: FSM states, source select codes
// and the priority wildcard opcode decoder.
package opcode_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_REQ,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Returns {err, sel}; the first matching pattern wins, 000? is unmatched.
  function automatic logic [2:0] decode_opcode(input logic [3:0] op);
    logic [2:0] res;
    res = {1'b1, SEL_A};
    casez (op)
      4'b1???: res = {1'b0, SEL_A};
      4'b01??: res = {1'b0, SEL_B};
      4'b001?: res = {1'b0, SEL_C};
      default: res = {1'b1, SEL_A};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// DEPTH x 4-bit synchronous FIFO with registered full/empty state.
// Push is ignored when full and pop when empty; the head is read combinationally.
module opcode_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opcode_src_scheduler.sv
// Queues opcodes, decodes each to source A/B/C and runs one req/valid transaction
// at a time, returning the captured data on a valid/ready port; drops are counted.
module opcode_src_scheduler
  import opcode_sched_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  output logic [2:0]       src_req,
  input  logic [2:0]       src_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] c_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = '1;
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       opcode_q;
  logic [3:0]       fifo_dout;
  logic [1:0]       sel_q;
  logic [TW-1:0]    tmo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [2:0]       dec;
  logic [2:0]       sel_onehot;
  logic [WIDTH-1:0] sel_data;
  logic             src_hit;
  logic             tmo_hit;

  opcode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   (cmd_opcode),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign dec       = decode_opcode(opcode_q);

  always_comb begin
    sel_onehot = 3'b000;
    sel_data   = '0;
    case (sel_q)
      SEL_A:   begin sel_onehot = 3'b001; sel_data = a_data; end
      SEL_B:   begin sel_onehot = 3'b010; sel_data = b_data; end
      SEL_C:   begin sel_onehot = 3'b100; sel_data = c_data; end
      default: begin sel_onehot = 3'b000; sel_data = '0;     end
    endcase
  end

  // Valid bits of non-selected sources are masked out; valid beats the timeout.
  assign src_hit = |(src_valid & sel_onehot);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fifo_pop  = 1'b0;
    src_req   = 3'b000;
    out_valid = 1'b0;
    err_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = dec[2] ? S_ERR : S_REQ;
      S_REQ: begin
        src_req = sel_onehot;
        if (src_hit)      state_nx = S_RESP;
        else if (tmo_hit) state_nx = S_ERR;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      S_ERR: begin
        err_pulse = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      sel_q     <= SEL_A;
      tmo_cnt   <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (fifo_pop) opcode_q <= fifo_dout;
        S_DECODE: begin
          if (!dec[2]) begin
            sel_q   <= dec[1:0];
            tmo_cnt <= '0;
          end
        end
        S_REQ: begin
          if (src_hit) begin
            out_data <= sel_data;
            out_sel  <= sel_q;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        S_ERR: if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_src_scheduler.sv
// Directed bench for opcode_src_scheduler: one task per scenario, each checking
// its own hand-computed expectations.
module tb_opcode_src_scheduler;

  localparam int WIDTH   = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [2:0]       src_req;
  logic [2:0]       src_valid;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] c_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             err_pulse;
  logic [7:0]       err_count;
  logic             busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  opcode_src_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .src_req    (src_req),
    .src_valid  (src_valid),
    .a_data     (a_data),
    .b_data     (b_data),
    .c_data     (c_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [3:0] op);
    cmd_opcode = op;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    cmd_opcode = 4'b0000;
  endtask

  task automatic wait_out_valid(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else begin tick(); n++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'b0; src_valid = 3'b0;
    a_data = '0; b_data = '0; c_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (src_req !== 3'b000) $display("[TB] FAIL reset_src_req got %b want 000", src_req); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (err_pulse !== 1'b0) $display("[TB] FAIL reset_err_pulse got %b want 0", err_pulse); else passed++;
    total++; if (err_count !== 8'd0) $display("[TB] FAIL reset_err_count got %0d want 0", err_count); else passed++;
    total++; if ({out_data, out_sel} !== 4'b0000) $display("[TB] FAIL reset_out got %b/%0d want 00/0", out_data, out_sel); else passed++;
  endtask

  task automatic test_single();
    src_valid = 3'b001; a_data = 2'b00; out_ready = 1'b0;
    push_op(4'b1010);
    tick();
    total++; if (src_req !== 3'b000) $display("[TB] FAIL single_req_early got %b want 000", src_req); else passed++;
    tick();
    total++; if (src_req !== 3'b001) $display("[TB] FAIL single_req got %b want 001", src_req); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL single_valid_early got %b want 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 2'b00 || out_sel !== 2'd0) $display("[TB] FAIL single_result got %b/%0d want 00/0", out_data, out_sel); else passed++;
    total++; if (src_req !== 3'b000) $display("[TB] FAIL single_req_resp got %b want 000", src_req); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL single_done got valid=%b busy=%b want 0/0", out_valid, busy); else passed++;
    out_ready = 1'b0; src_valid = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_data [2];
    logic [1:0] exp_sel [2];
    bit ok;
    exp_data = '{2'b01, 2'b10};
    exp_sel  = '{2'd1, 2'd2};
    src_valid = 3'b111; a_data = 2'b11; b_data = 2'b01; c_data = 2'b10; out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 4'b0110;
    tick();
    cmd_opcode = 4'b0011;
    tick();
    cmd_valid = 1'b0; cmd_opcode = 4'b0000;
    for (int r = 0; r < 2; r++) begin
      wait_out_valid(ok);
      total++; if (!ok) $display("[TB] FAIL b2b_wait%0d got no out_valid want out_valid", r); else passed++;
      total++; if (out_data !== exp_data[r] || out_sel !== exp_sel[r])
        $display("[TB] FAIL b2b_result%0d got %b/%0d want %b/%0d", r, out_data, out_sel, exp_data[r], exp_sel[r]);
      else passed++;
      tick();
    end
    out_ready = 1'b0; src_valid = 3'b000;
  endtask

  task automatic test_error();
    src_valid = 3'b000;
    push_op(4'b0001);
    tick();
    total++; if (err_pulse !== 1'b0) $display("[TB] FAIL err_pulse_early got %b want 0", err_pulse); else passed++;
    tick();
    total++; if (err_pulse !== 1'b1 || src_req !== 3'b000) $display("[TB] FAIL err_pulse got pulse=%b req=%b want 1/000", err_pulse, src_req); else passed++;
    tick();
    total++; if (err_pulse !== 1'b0) $display("[TB] FAIL err_pulse_width got %b want 0", err_pulse); else passed++;
    total++; if (err_count !== 8'd1) $display("[TB] FAIL err_count1 got %0d want 1", err_count); else passed++;
  endtask

  task automatic test_timeout();
    int cnt;
    src_valid = 3'b110;
    push_op(4'b1000);
    tick(); tick();
    cnt = 0;
    repeat (15) begin
      if (src_req === 3'b001) cnt++;
      tick();
    end
    total++; if (cnt != 15) $display("[TB] FAIL tmo_req_cycles got %0d want 15", cnt); else passed++;
    total++; if (err_pulse !== 1'b1 || src_req !== 3'b000) $display("[TB] FAIL tmo_err got pulse=%b req=%b want 1/000", err_pulse, src_req); else passed++;
    tick();
    total++; if (err_count !== 8'd2 || busy !== 1'b0) $display("[TB] FAIL tmo_count got %0d busy=%b want 2/0", err_count, busy); else passed++;
    src_valid = 3'b000;
  endtask

  task automatic test_fill();
    logic [3:0] ops [5];
    logic [1:0] exp_data [5];
    logic [1:0] exp_sel [5];
    bit ok;
    int w;
    ops      = '{4'b1100, 4'b0100, 4'b0010, 4'b1111, 4'b0101};
    exp_data = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    src_valid = 3'b111; a_data = 2'b01; b_data = 2'b10; c_data = 2'b11; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (cmd_ready !== 1'b1 && w < 20) begin tick(); w++; end
      push_op(ops[k]);
    end
    total++; if (cmd_ready !== 1'b0) $display("[TB] FAIL fill_full got cmd_ready=%b want 0", cmd_ready); else passed++;
    total++; if (out_valid !== 1'b1 || out_data !== 2'b01 || out_sel !== 2'd0)
      $display("[TB] FAIL fill_head got v=%b %b/%0d want 1 01/0", out_valid, out_data, out_sel);
    else passed++;
    repeat (3) tick();
    total++; if (out_data !== 2'b01 || cmd_ready !== 1'b0) $display("[TB] FAIL fill_hold got %b ready=%b want 01/0", out_data, cmd_ready); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_out_valid(ok);
      total++; if (!ok) $display("[TB] FAIL fill_wait%0d got no out_valid want out_valid", k); else passed++;
      total++; if (out_data !== exp_data[k] || out_sel !== exp_sel[k])
        $display("[TB] FAIL fill_result%0d got %b/%0d want %b/%0d", k, out_data, out_sel, exp_data[k], exp_sel[k]);
      else passed++;
      tick();
      if (k == 0) begin
        total++; if (cmd_ready !== 1'b0) $display("[TB] FAIL fill_pop_full got cmd_ready=%b want 0", cmd_ready); else passed++;
      end
    end
    total++; if (busy !== 1'b0) $display("[TB] FAIL fill_drained got busy=%b want 0", busy); else passed++;
    out_ready = 1'b0; src_valid = 3'b000;
  endtask

  task automatic test_saturate();
    src_valid = 3'b000;
    repeat (252) begin
      push_op(4'b0000);
      repeat (3) tick();
    end
    total++; if (err_count !== 8'd254) $display("[TB] FAIL sat_254 got %0d want 254", err_count); else passed++;
    push_op(4'b0001);
    repeat (3) tick();
    total++; if (err_count !== 8'd255) $display("[TB] FAIL sat_255 got %0d want 255", err_count); else passed++;
    push_op(4'b0001);
    tick(); tick();
    total++; if (err_pulse !== 1'b1) $display("[TB] FAIL sat_pulse got %b want 1", err_pulse); else passed++;
    tick();
    total++; if (err_count !== 8'd255) $display("[TB] FAIL sat_hold got %0d want 255", err_count); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    src_valid = 3'b000;
    push_op(4'b1000);
    n = 0;
    while (src_req === 3'b000 && n < 10) begin tick(); n++; end
    total++; if (src_req !== 3'b001) $display("[TB] FAIL rmid_req got %b want 001", src_req); else passed++;
    rst = 1'b1;
    tick();
    total++; if (src_req !== 3'b000 || out_valid !== 1'b0) $display("[TB] FAIL rmid_outs got req=%b v=%b want 000/0", src_req, out_valid); else passed++;
    total++; if (err_count !== 8'd0) $display("[TB] FAIL rmid_count got %0d want 0", err_count); else passed++;
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL rmid_state got ready=%b busy=%b want 1/0", cmd_ready, busy); else passed++;
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (err_pulse !== 1'b0 || src_req !== 3'b000) pulses++;
    end
    total++; if (pulses != 0 || busy !== 1'b0) $display("[TB] FAIL rmid_after got activity=%0d busy=%b want 0/0", pulses, busy); else passed++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_timeout();
    test_fill();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
